wb_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline writeback path and a multicycle execution unit (the divider), which returns results out of band through a valid/ready handshake. The block sits between the wb stage and regs. It holds at most one pending divider result and drains it into idle write-port cycles. If the pipeline occupies the port for too long, it forces a pipeline bubble. Pending-result status is exported so ctrl can detect RAW hazards.

---
 rtl/wb_arbiter_if.sv | 31 +++
 rtl/wb_arbiter.sv | 104 ++++++++++
 tb/tb_wb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-port arbitration bus between the wb stage, the divider and the register file.
// The arbiter takes the slave view; the surrounding pipeline/divider take the master view.
interface wb_arbiter_if;
  logic        pipe_we_i;
  logic [4:0]  pipe_waddr_i;
  logic [31:0] pipe_wdata_i;
  logic        div_valid_i;
  logic [4:0]  div_waddr_i;
  logic [31:0] div_wdata_i;
  logic        div_ready_o;
  logic        hold_o;
  logic        pend_o;
  logic [4:0]  pend_waddr_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  modport master (
    output pipe_we_i, pipe_waddr_i, pipe_wdata_i,
    output div_valid_i, div_waddr_i, div_wdata_i,
    input  div_ready_o, hold_o, pend_o, pend_waddr_o,
    input  reg_we_o, reg_waddr_o, reg_wdata_o
  );

  modport slave (
    input  pipe_we_i, pipe_waddr_i, pipe_wdata_i,
    input  div_valid_i, div_waddr_i, div_wdata_i,
    output div_ready_o, hold_o, pend_o, pend_waddr_o,
    output reg_we_o, reg_waddr_o, reg_wdata_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, one buffered divider result
// drains into idle cycles. Define WB_ARB_STARVE_EN to enable the starvation counter / FORCE state.
module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("wb_arbiter: STARVE_MAX must be in 1..15");
  end

`ifdef WB_ARB_STARVE_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StPend = 2'd1, StForce = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StPend = 2'd1} state_e;
`endif

  state_e      state;
  logic [4:0]  buf_waddr;
  logic [31:0] buf_wdata;
  logic        pipe_hit;
  logic        release_buf;

  // A younger pipeline write to the same register supersedes the buffered result.
  assign pipe_hit    = bus.pipe_we_i && (bus.pipe_waddr_i == buf_waddr);
  assign release_buf = !bus.pipe_we_i || pipe_hit;

`ifdef WB_ARB_STARVE_EN
  localparam logic [3:0] StarveMaxW = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
  logic [3:0] cnt_inc;
  assign cnt_inc    = (starve_cnt == 4'hf) ? starve_cnt : starve_cnt + 4'd1;
  assign bus.hold_o = (state == StForce);
`else
  assign bus.hold_o = 1'b0;
`endif

  assign bus.div_ready_o  = (state == StIdle);
  assign bus.pend_o       = (state != StIdle);
  assign bus.pend_waddr_o = buf_waddr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= StIdle;
      buf_waddr       <= 5'd0;
      buf_wdata       <= 32'd0;
      bus.reg_we_o    <= 1'b0;
      bus.reg_waddr_o <= 5'd0;
      bus.reg_wdata_o <= 32'd0;
`ifdef WB_ARB_STARVE_EN
      starve_cnt      <= 4'd0;
`endif
    end else begin
      if (bus.pipe_we_i) begin
        bus.reg_we_o    <= (bus.pipe_waddr_i != 5'd0);
        bus.reg_waddr_o <= bus.pipe_waddr_i;
        bus.reg_wdata_o <= bus.pipe_wdata_i;
      end else if (state != StIdle) begin
        bus.reg_we_o    <= 1'b1;
        bus.reg_waddr_o <= buf_waddr;
        bus.reg_wdata_o <= buf_wdata;
      end else begin
        bus.reg_we_o    <= 1'b0;
      end

      case (state)
        StIdle: begin
          // Results for x0 complete the handshake but are dropped.
          if (bus.div_valid_i && (bus.div_waddr_i != 5'd0)) begin
            state     <= StPend;
            buf_waddr <= bus.div_waddr_i;
            buf_wdata <= bus.div_wdata_i;
          end
        end
        StPend: begin
          if (release_buf) begin
            state      <= StIdle;
`ifdef WB_ARB_STARVE_EN
            starve_cnt <= 4'd0;
          end else begin
            starve_cnt <= cnt_inc;
            if (cnt_inc >= StarveMaxW) begin
              state <= StForce;
            end
`endif
          end
        end
`ifdef WB_ARB_STARVE_EN
        StForce: begin
          if (release_buf) begin
            state      <= StIdle;
            starve_cnt <= 4'd0;
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; covers the starvation path when
// WB_ARB_STARVE_EN is defined and the unbounded-wait path otherwise.
module tb_wb_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  wb_arbiter_if bus_if ();

  wb_arbiter #(
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.pipe_we_i    = 1'b0;
    bus_if.pipe_waddr_i = 5'd0;
    bus_if.pipe_wdata_i = 32'd0;
    bus_if.div_valid_i  = 1'b0;
    bus_if.div_waddr_i  = 5'd0;
    bus_if.div_wdata_i  = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus_if.div_ready_o !== 1'b1) begin
        errors++; $display("FAIL reset_div_ready: got %b want 1", bus_if.div_ready_o);
      end
      checks++;
      if (bus_if.hold_o !== 1'b0 || bus_if.pend_o !== 1'b0 || bus_if.pend_waddr_o !== 5'd0) begin
        errors++;
        $display("FAIL reset_pend: got hold=%b pend=%b pend_waddr=%0d want 0 0 0",
                 bus_if.hold_o, bus_if.pend_o, bus_if.pend_waddr_o);
      end
      checks++;
      if (bus_if.reg_we_o !== 1'b0 || bus_if.reg_waddr_o !== 5'd0 ||
          bus_if.reg_wdata_o !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg: got we=%b waddr=%0d wdata=%h want 0 0 0",
                 bus_if.reg_we_o, bus_if.reg_waddr_o, bus_if.reg_wdata_o);
      end
      step();
    end
  endtask

  task automatic test_pipe_write();
    bus_if.pipe_we_i    = 1'b1;
    bus_if.pipe_waddr_i = 5'd5;
    bus_if.pipe_wdata_i = 32'h1234;
    step();
    bus_if.pipe_waddr_i = 5'd0;
    bus_if.pipe_wdata_i = 32'hffff;
    checks++;
    if (bus_if.reg_we_o !== 1'b1 || bus_if.reg_waddr_o !== 5'd5 ||
        bus_if.reg_wdata_o !== 32'h1234) begin
      errors++;
      $display("FAIL pipe_write_x5: got we=%b waddr=%0d wdata=%h want 1 5 00001234",
               bus_if.reg_we_o, bus_if.reg_waddr_o, bus_if.reg_wdata_o);
    end
    step();
    bus_if.pipe_we_i = 1'b0;
    checks++;
    if (bus_if.reg_we_o !== 1'b0) begin
      errors++; $display("FAIL pipe_write_x0: got we=%b want 0", bus_if.reg_we_o);
    end
    step();
    checks++;
    if (bus_if.reg_we_o !== 1'b0) begin
      errors++; $display("FAIL pipe_idle: got we=%b want 0", bus_if.reg_we_o);
    end
  endtask

  task automatic test_div_drain();
    bus_if.div_valid_i = 1'b1;
    bus_if.div_waddr_i = 5'd7;
    bus_if.div_wdata_i = 32'hdead;
    step();
    bus_if.div_valid_i = 1'b0;
    checks++;
    if (bus_if.pend_o !== 1'b1 || bus_if.div_ready_o !== 1'b0 || bus_if.pend_waddr_o !== 5'd7 ||
        bus_if.reg_we_o !== 1'b0) begin
      errors++;
      $display("FAIL div_pend: got pend=%b ready=%b pend_waddr=%0d we=%b want 1 0 7 0",
               bus_if.pend_o, bus_if.div_ready_o, bus_if.pend_waddr_o, bus_if.reg_we_o);
    end
    step();
    checks++;
    if (bus_if.reg_we_o !== 1'b1 || bus_if.reg_waddr_o !== 5'd7 ||
        bus_if.reg_wdata_o !== 32'hdead || bus_if.div_ready_o !== 1'b1 || bus_if.pend_o !== 1'b0) begin
      errors++;
      $display("FAIL div_drain: got we=%b waddr=%0d wdata=%h ready=%b pend=%b want 1 7 0000dead 1 0",
               bus_if.reg_we_o, bus_if.reg_waddr_o, bus_if.reg_wdata_o, bus_if.div_ready_o,
               bus_if.pend_o);
    end
    // Result for x0 completes the handshake and is dropped.
    bus_if.div_valid_i = 1'b1;
    bus_if.div_waddr_i = 5'd0;
    bus_if.div_wdata_i = 32'hbad0;
    step();
    bus_if.div_valid_i = 1'b0;
    checks++;
    if (bus_if.pend_o !== 1'b0 || bus_if.div_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL div_x0_discard: got pend=%b ready=%b want 0 1", bus_if.pend_o,
               bus_if.div_ready_o);
    end
    step();
    checks++;
    if (bus_if.reg_we_o !== 1'b0) begin
      errors++; $display("FAIL div_x0_no_write: got we=%b want 0", bus_if.reg_we_o);
    end
  endtask

  task automatic test_waw();
    bus_if.div_valid_i = 1'b1;
    bus_if.div_waddr_i = 5'd7;
    bus_if.div_wdata_i = 32'h5555;
    step();
    bus_if.div_valid_i  = 1'b0;
    bus_if.pipe_we_i    = 1'b1;
    bus_if.pipe_waddr_i = 5'd7;
    bus_if.pipe_wdata_i = 32'h1;
    checks++;
    if (bus_if.pend_o !== 1'b1) begin
      errors++; $display("FAIL waw_pend: got pend=%b want 1", bus_if.pend_o);
    end
    step();
    bus_if.pipe_we_i = 1'b0;
    checks++;
    if (bus_if.reg_we_o !== 1'b1 || bus_if.reg_waddr_o !== 5'd7 || bus_if.reg_wdata_o !== 32'h1 ||
        bus_if.pend_o !== 1'b0 || bus_if.div_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL waw_write: got we=%b waddr=%0d wdata=%h pend=%b ready=%b want 1 7 00000001 0 1",
               bus_if.reg_we_o, bus_if.reg_waddr_o, bus_if.reg_wdata_o, bus_if.pend_o,
               bus_if.div_ready_o);
    end
    step();
    checks++;
    if (bus_if.reg_we_o !== 1'b0) begin
      errors++; $display("FAIL waw_dropped: got we=%b want 0", bus_if.reg_we_o);
    end
  endtask

  task automatic test_starve();
    logic exp_hold;
    int   extra;
    bus_if.div_valid_i = 1'b1;
    bus_if.div_waddr_i = 5'd9;
    bus_if.div_wdata_i = 32'h9999;
    step();
    bus_if.div_valid_i = 1'b0;
`ifdef WB_ARB_STARVE_EN
    extra = 0;
`else
    extra = 4;
`endif
    for (int i = 1; i <= 4 + extra; i++) begin
      bus_if.pipe_we_i    = 1'b1;
      bus_if.pipe_waddr_i = 5'(((i - 1) % 4) + 1);
      bus_if.pipe_wdata_i = 32'(i);
      step();
`ifdef WB_ARB_STARVE_EN
      exp_hold = (i >= 4);
`else
      exp_hold = 1'b0;
`endif
      checks++;
      if (bus_if.reg_we_o !== 1'b1 || bus_if.reg_waddr_o !== 5'(((i - 1) % 4) + 1) ||
          bus_if.reg_wdata_o !== 32'(i) || bus_if.pend_o !== 1'b1 || bus_if.hold_o !== exp_hold) begin
        errors++;
        $display("FAIL starve_block_%0d: got we=%b waddr=%0d wdata=%h pend=%b hold=%b want 1 %0d %h 1 %b",
                 i, bus_if.reg_we_o, bus_if.reg_waddr_o, bus_if.reg_wdata_o, bus_if.pend_o,
                 bus_if.hold_o, ((i - 1) % 4) + 1, 32'(i), exp_hold);
      end
    end
    bus_if.pipe_we_i = 1'b0;
    step();
    checks++;
    if (bus_if.reg_we_o !== 1'b1 || bus_if.reg_waddr_o !== 5'd9 ||
        bus_if.reg_wdata_o !== 32'h9999 || bus_if.hold_o !== 1'b0 || bus_if.pend_o !== 1'b0) begin
      errors++;
      $display("FAIL starve_drain: got we=%b waddr=%0d wdata=%h hold=%b pend=%b want 1 9 00009999 0 0",
               bus_if.reg_we_o, bus_if.reg_waddr_o, bus_if.reg_wdata_o, bus_if.hold_o,
               bus_if.pend_o);
    end
  endtask

  task automatic test_back_to_back();
    bus_if.div_valid_i = 1'b1;
    bus_if.div_waddr_i = 5'd3;
    bus_if.div_wdata_i = 32'haaaa;
    step();
    bus_if.div_waddr_i = 5'd4;
    bus_if.div_wdata_i = 32'hbbbb;
    checks++;
    if (bus_if.div_ready_o !== 1'b0 || bus_if.pend_waddr_o !== 5'd3) begin
      errors++;
      $display("FAIL b2b_busy: got ready=%b pend_waddr=%0d want 0 3", bus_if.div_ready_o,
               bus_if.pend_waddr_o);
    end
    step();
    checks++;
    if (bus_if.reg_we_o !== 1'b1 || bus_if.reg_waddr_o !== 5'd3 ||
        bus_if.reg_wdata_o !== 32'haaaa || bus_if.div_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got we=%b waddr=%0d wdata=%h ready=%b want 1 3 0000aaaa 1",
               bus_if.reg_we_o, bus_if.reg_waddr_o, bus_if.reg_wdata_o, bus_if.div_ready_o);
    end
    step();
    bus_if.div_valid_i = 1'b0;
    checks++;
    if (bus_if.pend_o !== 1'b1 || bus_if.pend_waddr_o !== 5'd4 || bus_if.reg_we_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_pend: got pend=%b pend_waddr=%0d we=%b want 1 4 0",
               bus_if.pend_o, bus_if.pend_waddr_o, bus_if.reg_we_o);
    end
    step();
    checks++;
    if (bus_if.reg_we_o !== 1'b1 || bus_if.reg_waddr_o !== 5'd4 ||
        bus_if.reg_wdata_o !== 32'hbbbb) begin
      errors++;
      $display("FAIL b2b_second: got we=%b waddr=%0d wdata=%h want 1 4 0000bbbb",
               bus_if.reg_we_o, bus_if.reg_waddr_o, bus_if.reg_wdata_o);
    end
  endtask

  task automatic test_reset_pend();
    bus_if.div_valid_i = 1'b1;
    bus_if.div_waddr_i = 5'd12;
    bus_if.div_wdata_i = 32'hc0de;
    step();
    bus_if.div_valid_i = 1'b0;
    checks++;
    if (bus_if.pend_o !== 1'b1) begin
      errors++; $display("FAIL rstpend_pend: got pend=%b want 1", bus_if.pend_o);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (bus_if.pend_o !== 1'b0 || bus_if.div_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstpend_release: got pend=%b ready=%b want 0 1", bus_if.pend_o,
               bus_if.div_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus_if.reg_we_o !== 1'b0) begin
        errors++; $display("FAIL rstpend_no_write_%0d: got we=%b want 0", i, bus_if.reg_we_o);
      end
      step();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_pipe_write();
    test_div_drain();
    test_waw();
    test_starve();
    test_back_to_back();
    test_reset_pend();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
